// File: rtl/dma_serial_tx.sv
// Byte-to-serial transmitter: start bit, 8 data bits LSB-first, optional parity, stop bit.
// Optional even-parity bit enabled by defining DMA_TX_PARITY_EN.
module dma_serial_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] dato,
  input  logic              dato_valid,
  output logic              dato_ready,
  output logic              senal_tr,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IDX_W = 3;

  if (DATA_W != 8) begin : g_bad_data_w
    $error("dma_serial_tx supports DATA_W == 8 only");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("dma_serial_tx requires CLKS_PER_BIT >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   sh_q, sh_d;
  logic                senal_d, ready_d, busy_d, done_d;
`ifdef DMA_TX_PARITY_EN
  logic                par_q, par_d;
`endif

  logic cnt_last;
  logic accept;

  assign cnt_last = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign accept   = (state_q == S_IDLE) && dato_valid && dato_ready;

  // State and registered datapath/outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      sh_q       <= '0;
      senal_tr   <= 1'b1;
      dato_ready <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef DMA_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      sh_q       <= sh_d;
      senal_tr   <= senal_d;
      dato_ready <= ready_d;
      busy       <= busy_d;
      done       <= done_d;
`ifdef DMA_TX_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  // Next-state logic: every non-idle state advances on the counter wrap
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_START;
      S_START: if (cnt_last) state_d = S_DATA;
      S_DATA: begin
        if (cnt_last && (idx_q == IDX_W'(7))) begin
`ifdef DMA_TX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef DMA_TX_PARITY_EN
      S_PARITY: if (cnt_last) state_d = S_STOP;
`endif
      S_STOP:  if (cnt_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the line, counters and handshake flags
  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    senal_d = senal_tr;
    ready_d = dato_ready;
    busy_d  = busy;
    done_d  = 1'b0;
`ifdef DMA_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q != S_IDLE) begin
      cnt_d = cnt_last ? '0 : cnt_q + CNT_W'(1);
    end
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          sh_d    = dato;
          senal_d = 1'b0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          idx_d   = '0;
`ifdef DMA_TX_PARITY_EN
          par_d   = ^dato;
`endif
        end
      end
      S_START: begin
        if (cnt_last) begin
          senal_d = sh_q[0];
          sh_d    = sh_q >> 1;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (cnt_last) begin
          if (idx_q == IDX_W'(7)) begin
`ifdef DMA_TX_PARITY_EN
            senal_d = par_q;
`else
            senal_d = 1'b1;
`endif
          end else begin
            senal_d = sh_q[0];
            sh_d    = sh_q >> 1;
            idx_d   = idx_q + IDX_W'(1);
          end
        end
      end
`ifdef DMA_TX_PARITY_EN
      S_PARITY: if (cnt_last) senal_d = 1'b1;
`endif
      S_STOP: begin
        if (cnt_last) begin
          senal_d = 1'b1;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dma_serial_tx.sv
// Directed self-checking bench for dma_serial_tx (CLKS_PER_BIT = 4); models the pin output flop.
module tb_dma_serial_tx;

  localparam int CLKS = 4;
`ifdef DMA_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int F = NB * CLKS;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] dato;
  logic       dato_valid;
  logic       dato_ready;
  logic       senal_tr;
  logic       busy;
  logic       done;
  logic       trans;

  int n_checks = 0;
  int n_fail   = 0;

  dma_serial_tx #(.CLKS_PER_BIT(CLKS), .DATA_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dato       (dato),
    .dato_valid (dato_valid),
    .dato_ready (dato_ready),
    .senal_tr   (senal_tr),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Downstream single-flop output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) trans <= 1'b1;
    else        trans <= senal_tr;
  end

  function automatic logic exp_bit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[3'(b - 1)];
`ifdef DMA_TX_PARITY_EN
    if (b == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at the negedge just before the handshake edge with dato/dato_valid set up.
  task automatic run_frame(input logic [7:0] d, input bit disturb);
    logic prev;
    prev = 1'b1;
    @(negedge clk);
    for (int j = 0; j < F; j++) begin
      if (!disturb) dato_valid = 1'b0;
      else begin
        dato       = 8'h3C;
        dato_valid = (j < F - 1) ? j[0] : 1'b0;
      end
      check("frame_bit", senal_tr, exp_bit(d, j / CLKS));
      check("frame_busy", busy, 1'b1);
      check("frame_ready", dato_ready, 1'b0);
      check("frame_done_early", done, 1'b0);
      check("trans_delay", trans, prev);
      prev = senal_tr;
      @(negedge clk);
    end
    check("end_done", done, 1'b1);
    check("end_ready", dato_ready, 1'b1);
    check("end_busy", busy, 1'b0);
    check("end_line", senal_tr, 1'b1);
    check("end_trans", trans, prev);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    check("idle_line", senal_tr, 1'b1);
  endtask

  initial begin
    int first_done, second_done, hi_cnt;
    logic e;
    rst_n      = 1'b0;
    dato       = 8'h00;
    dato_valid = 1'b0;
    @(negedge clk);
    check("rst_line", senal_tr, 1'b1);
    check("rst_ready", dato_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);

    // Release reset with a byte already offered: accepted on the first edge
    dato       = 8'hA5;
    dato_valid = 1'b1;
    rst_n      = 1'b1;
    run_frame(8'hA5, 1'b0);

    // Single-cycle valid pulse in IDLE
    repeat (3) @(negedge clk);
    dato       = 8'h01;
    dato_valid = 1'b1;
    run_frame(8'h01, 1'b0);

    // Inputs toggled during the frame must be ignored
    repeat (2) @(negedge clk);
    dato       = 8'h5A;
    dato_valid = 1'b1;
    run_frame(8'h5A, 1'b1);

    // Asynchronous reset mid-DATA
    repeat (2) @(negedge clk);
    dato       = 8'hA5;
    dato_valid = 1'b1;
    @(negedge clk);
    dato_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("pre_rst_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_line", senal_tr, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ready", dato_ready, 1'b1);
    check("mid_rst_done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 20; j++) begin
      check("post_rst_line", senal_tr, 1'b1);
      check("post_rst_busy", busy, 1'b0);
      @(negedge clk);
    end

    // Back-to-back with dato_valid held high: 0x00 then 0xFF
    dato       = 8'h00;
    dato_valid = 1'b1;
    @(negedge clk);
    dato        = 8'hFF;
    first_done  = -1;
    second_done = -1;
    hi_cnt      = 0;
    for (int j = 0; j <= 2 * F + 1; j++) begin
      if (j == F + 1) dato_valid = 1'b0;
      if (j < F)       e = exp_bit(8'h00, j / CLKS);
      else if (j == F) e = 1'b1;
      else if (j <= 2 * F) e = exp_bit(8'hFF, (j - F - 1) / CLKS);
      else             e = 1'b1;
      check("b2b_bit", senal_tr, e);
      if (j <= F && senal_tr === 1'b1) hi_cnt++;
      if (done === 1'b1) begin
        if (first_done < 0) first_done = j;
        else if (second_done < 0) second_done = j;
      end
      @(negedge clk);
    end
    check_int("b2b_gap_high", hi_cnt, CLKS + 1);
    check_int("b2b_first_done", first_done, F);
    check_int("b2b_done_spacing", second_done - first_done, F + 1);
    check("b2b_done_clear", done, 1'b0);
    check("b2b_idle_ready", dato_ready, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_serial_tx.md
Name: dma_serial_tx

Overview:
- Byte-to-serial transmitter for the DMA/protocol path.
- Accepts bytes from the DMA transfer engine over a valid/ready handshake.
- Frames each byte as start bit, 8 data bits LSB-first, optional parity bit, then stop bit.
- Drives the raw line `senal_tr`, which feeds directly into the single-flop output register stage that produces the pin-level `trans` signal.

Parameters:
- CLKS_PER_BIT, 868: clock cycles per serial bit (100 MHz / 115200). Legal range >= 2; simulation uses 4.
- DATA_W, 8: data byte width. Only 8 is supported; the parameter exists for elaboration checks.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- dato  input  DATA_W  byte to transmit; sampled only on handshake.
- dato_valid  input  1  DMA presents a byte.
- dato_ready  output  1  block can accept a byte.
- senal_tr  output  1  serial line, idle high; registered output.
- busy  output  1  a frame is in progress.
- done  output  1  one-cycle pulse at frame completion.

Behaviour:
- Reset (asynchronous, rst_n=0), effective immediately, including mid-frame:
  - State IDLE.
  - senal_tr=1, dato_ready=1, busy=0, done=0.
  - Bit counter and bit index cleared.
  - A frame in flight is abandoned; nothing resumes after reset release.
- States:
  - IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE:
  - dato_ready=1, busy=0, senal_tr=1.
  - Handshake: dato_valid && dato_ready at a rising edge. On that edge:
    - Latch dato into the shift register.
    - Go to START, with senal_tr=0, dato_ready=0, busy=1.
- Bit counter counts 0..CLKS_PER_BIT-1 in every non-IDLE state. Each bit is held exactly CLKS_PER_BIT cycles.
- START: after CLKS_PER_BIT cycles -> DATA, with senal_tr = latched bit 0.
- DATA:
  - 3-bit index runs 0..7; each bit is held CLKS_PER_BIT cycles.
  - After bit 7 -> PARITY if enabled, else STOP.
- STOP:
  - senal_tr=1 for CLKS_PER_BIT cycles.
  - On the last cycle's edge -> IDLE, with dato_ready=1, busy=0, done=1 for exactly one cycle.
- Frame length, from handshake edge to the done edge:
  - 10*CLKS_PER_BIT cycles without parity.
  - 11*CLKS_PER_BIT cycles with parity.
- Back-to-back transfers: if dato_valid is held high, the next byte is accepted on the first IDLE cycle's edge. The line is therefore high for CLKS_PER_BIT+1 cycles between frames.
- Inputs are ignored while not in IDLE:
  - dato_valid while busy has no effect.
  - dato changes while busy do not alter the frame in flight.
- senal_tr is driven from a flop only; it never carries combinational glitches.
- Counter width is $clog2(CLKS_PER_BIT). Wrap from CLKS_PER_BIT-1 to 0 coincides with the bit advance.
- Reset released while dato_valid=1: the byte is accepted on the first rising edge after release.

Optional Feature:
- Macro: DMA_TX_PARITY_EN.
- Defined:
  - PARITY state inserted after DATA.
  - senal_tr = even parity = XOR of the 8 latched data bits, held CLKS_PER_BIT cycles.
  - Frame length is 11*CLKS_PER_BIT.
- Undefined:
  - No PARITY state and no parity logic synthesized.
  - DATA goes directly to STOP; frame length is 10*CLKS_PER_BIT.

Test Plan (CLKS_PER_BIT=4):
- Reset: rst_n=0 asserted mid-DATA -> in the same cycle senal_tr=1, busy=0, dato_ready=1, done=0. After release the line stays high with no further bits.
- Single byte, parity off: dato=0xA5, dato_valid pulsed one cycle in IDLE -> senal_tr sequence 0,1,0,1,0,0,1,0,1,1, each level 4 cycles. done pulses once, 40 cycles after the handshake edge.
- Single byte, parity on (DMA_TX_PARITY_EN): dato=0xA5 -> data bits as above, parity bit 0, then stop 1. done at 44 cycles. Also dato=0x01 -> parity bit 1.
- Back-to-back: dato_valid held high with 0x00 then 0xFF -> two frames. Line high exactly 5 cycles between the end of frame-1 data and the start bit of frame 2. Two done pulses 41 cycles apart.
- Ignore while busy: change dato to 0x3C and toggle dato_valid during frame 0x5A -> transmitted bits match 0x5A only. dato_ready stays 0 throughout the frame.
- Downstream check: connect to the output register stage -> `trans` equals senal_tr delayed by exactly one clock for the entire frame.
